instr_fifo: RTL and testbench
=============================

INSTR_FIFO -- requirements
Module: instr_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 32, number of instruction entries (power of two, >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 lower_word  input  32  instruction bits [31:0].
REQ-005 lower_write_en  input  1  load lower_word into staging.
REQ-006 middle_word  input  32  instruction bits [63:32].
REQ-007 middle_write_en  input  1  load middle_word into staging.
REQ-008 upper_word  input  16  instruction bits [79:64].
REQ-009 upper_write_en  input  1  commit the assembled 80-bit instruction to the FIFO.
REQ-010 instr_out  output  80 (instr_type)  head instruction.
REQ-011 instr_valid  output  1  FIFO non-empty; instr_out meaningful.
REQ-012 instr_ready  input  1  consumer accepts head this cycle.
REQ-013 full  output  1  count == FIFO_DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 count  output  $clog2(FIFO_DEPTH)+1  entries held.
REQ-016 overflow  output  1  sticky: a commit was dropped.

Function
REQ-017 Staging registers lower/middle SHALL load on their enables; they are not cleared by a commit.
REQ-018 On upper_write_en the committed 80-bit vector SHALL be {upper_word, middle, lower}, where middle/lower are the same-cycle inputs if their enable is high that cycle, else the staged values.
REQ-019 The 80-bit vector SHALL be stored as instr_type via the package conversion function: buffer_addr=[79:56], acc_addr=[55:40], length=[39:8], opcode=[7:0].
REQ-020 Push SHALL occur when upper_write_en and (not full or pop this cycle); pop SHALL occur when instr_valid and instr_ready.
REQ-021 Latency: instruction committed in cycle N SHALL appear at instr_out with instr_valid in cycle N+1 when the FIFO was empty; no same-cycle bypass.
REQ-022 instr_out SHALL equal the entry at the read pointer; its value when empty is don't-care but SHALL not be X after reset (storage initialised or output gated to 0).
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when full (push accepted) and never when empty (no pop possible).
REQ-024 Commit while full without pop SHALL be dropped, FIFO contents unchanged, overflow set to 1 next cycle and held until reset.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow.
REQ-026 Strict FIFO order; no reordering, no duplication.
REQ-027 full, empty, instr_valid SHALL be derived from registered count (instr_valid = not empty).

Reset
REQ-028 On rst high at a clock edge: pointers=0, count=0, empty=1, full=0, instr_valid=0, overflow=0, staging registers=0.
REQ-029 rst SHALL override any same-cycle push or pop; a partially staged instruction SHALL be discarded.
REQ-030 Storage array contents need not reset, subject to REQ-022.

Structure
REQ-031 instr_type, its field widths and the bits-to-instruction conversion function SHALL come from the shared tpu_pkg; no local redefinition.
REQ-032 FIFO_DEPTH default SHALL be added to tpu_pkg as INSTR_FIFO_DEPTH = 32.
REQ-033 One sub-module is natural: sync_fifo (generic width/depth storage, pointers, count); instr_fifo adds staging, assembly, overflow.

Verification
REQ-034 After reset, write lower=0x00000A01, middle=0x00C00000, upper=0x1234 on successive cycles -> next cycle instr_valid=1, buffer_addr=0x123400, acc_addr=0xC000, length=0x0000000A, opcode=0x01.
REQ-035 All three enables high in one cycle with lower=0x11111111, middle=0x22222222, upper=0x3333 -> head = 0x33332222222211111111 (same-cycle forwarding).
REQ-036 Commit 32 instructions with instr_ready=0 -> full=1, count=32; 33rd commit -> overflow=1, pop all 32 in original order, 33rd never appears.
REQ-037 Full FIFO, commit and instr_ready=1 same cycle -> count stays 32, overflow stays 0, new entry emerges last.
REQ-038 Push/pop 100 instructions with random instr_ready -> pointer wrap, order preserved, count matches model every cycle.
REQ-039 Assert rst with 5 entries held and a commit pending -> next cycle count=0, empty=1, instr_valid=0, overflow=0; subsequent upper-only commit uses zeroed staging.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: the packed instruction type, its field widths,
// the raw-bits-to-instruction conversion and default queue depths.
package tpu_pkg;

    localparam int unsigned INSTR_WIDTH       = 80;
    localparam int unsigned BUFFER_ADDR_WIDTH = 24;
    localparam int unsigned ACC_ADDR_WIDTH    = 16;
    localparam int unsigned LENGTH_WIDTH      = 32;
    localparam int unsigned OPCODE_WIDTH      = 8;

    localparam int unsigned INSTR_FIFO_DEPTH  = 32;

    // Field order matches the raw bit layout, most significant first.
    typedef struct packed {
        logic [BUFFER_ADDR_WIDTH-1:0] buffer_addr;  // [79:56]
        logic [ACC_ADDR_WIDTH-1:0]    acc_addr;     // [55:40]
        logic [LENGTH_WIDTH-1:0]      length;       // [39:8]
        logic [OPCODE_WIDTH-1:0]      opcode;       // [7:0]
    } instr_type;

    function automatic instr_type bits_to_instr(input logic [INSTR_WIDTH-1:0] bits);
        instr_type instr;
        instr.buffer_addr = bits[79:56];
        instr.acc_addr    = bits[55:40];
        instr.length      = bits[39:8];
        instr.opcode      = bits[7:0];
        return instr;
    endfunction

endpackage

// File: rtl/instr_fifo_sync_fifo.sv
// Generic synchronous FIFO: storage array, wrapping pointers and occupancy.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_req_i        request a push; accepted when not full or when popping
//   rd_req_i        request a pop; accepted when not empty
//   wdata_i         data to push
//   rdata_o         entry at the read pointer, forced to zero when empty
//   count_o         entries held (0..DEPTH)
//   full_o/empty_o  occupancy flags derived from the registered count
//   push_o/pop_o    accepted push / pop this cycle
module sync_fifo #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_req_i,
    input  logic                     rd_req_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     push_o,
    output logic                     pop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign pop_o  = rd_req_i & ~empty_o;
    assign push_o = wr_req_i & (~full_o | pop_o);

    // Storage is never reset; the output is gated so it is never X.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // DEPTH is a power of two, so pointer overflow wraps naturally.
        if (push_o) wptr_d = wptr_q + 1'b1;
        if (pop_o)  rptr_d = rptr_q + 1'b1;
        case ({push_o, pop_o})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_o) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fifo.sv
// Instruction FIFO: assembles an 80-bit instruction from three writes
// (lower 32, middle 32, upper 16 bits; the upper write commits) and queues
// it for the consumer.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   lower_word/lower_write_en         stage instruction bits [31:0]
//   middle_word/middle_write_en       stage instruction bits [63:32]
//   upper_word/upper_write_en         bits [79:64]; commits the instruction
//   instr_out/instr_valid/instr_ready head instruction handshake
//   full, empty, count                occupancy
//   overflow                          sticky: a commit was dropped while full
module instr_fifo
    import tpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = INSTR_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  lower_word,
    input  logic                         lower_write_en,
    input  logic [31:0]                  middle_word,
    input  logic                         middle_write_en,
    input  logic [15:0]                  upper_word,
    input  logic                         upper_write_en,
    output instr_type                    instr_out,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         overflow
);

    logic [31:0] lower_q, lower_d;
    logic [31:0] middle_q, middle_d;
    logic        overflow_q, overflow_d;

    logic [31:0]            lower_sel;
    logic [31:0]            middle_sel;
    instr_type              commit_instr;
    logic [INSTR_WIDTH-1:0] head_bits;
    logic                   push;
    logic                   pop;

    // Same-cycle writes bypass the staging registers so all three words
    // may arrive together.
    assign lower_sel    = lower_write_en  ? lower_word  : lower_q;
    assign middle_sel   = middle_write_en ? middle_word : middle_q;
    assign commit_instr = bits_to_instr({upper_word, middle_sel, lower_sel});

    sync_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_req_i (upper_write_en),
        .rd_req_i (instr_ready),
        .wdata_i  (commit_instr),
        .rdata_o  (head_bits),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty),
        .push_o   (push),
        .pop_o    (pop)
    );

    assign instr_out   = instr_type'(head_bits);
    assign instr_valid = ~empty;
    assign overflow    = overflow_q;

    always_comb begin
        lower_d    = lower_write_en  ? lower_word  : lower_q;
        middle_d   = middle_write_en ? middle_word : middle_q;
        // A commit that the FIFO refused can only mean full without a pop.
        overflow_d = overflow_q | (upper_write_en & ~push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lower_q    <= '0;
            middle_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            lower_q    <= lower_d;
            middle_q   <= middle_d;
            overflow_q <= overflow_d;
        end
    end

    // Only the accepted-pop strobe is unused at this level.
    logic unused_pop;
    assign unused_pop = pop;

endmodule

// File: tb/tb_instr_fifo.sv
module tb_instr_fifo;
    import tpu_pkg::*;

    localparam int unsigned DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lower_word, middle_word;
    logic [15:0] upper_word;
    logic        lower_write_en, middle_write_en, upper_write_en;
    logic        instr_ready;
    instr_type   instr_out;
    logic        instr_valid, full, empty, overflow;
    logic [5:0]  count;

    instr_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .lower_word      (lower_word),
        .lower_write_en  (lower_write_en),
        .middle_word     (middle_word),
        .middle_write_en (middle_write_en),
        .upper_word      (upper_word),
        .upper_write_en  (upper_write_en),
        .instr_out       (instr_out),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of raw 80-bit instructions plus staging words.
    logic [79:0] q[$];
    logic [31:0] lo_m, mid_m;
    bit          ovf_m;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [79:0] v;
        @(posedge clk);
        if (rst) begin
            q.delete();
            lo_m  = '0;
            mid_m = '0;
            ovf_m = 0;
        end else begin
            v = {upper_word, middle_write_en ? middle_word : mid_m,
                 lower_write_en ? lower_word : lo_m};
            if (q.size() != 0 && instr_ready) void'(q.pop_front());
            if (upper_write_en) begin
                if (q.size() < DEPTH) q.push_back(v);
                else ovf_m = 1;
            end
            if (lower_write_en)  lo_m  = lower_word;
            if (middle_write_en) mid_m = middle_word;
        end
        #1;
        chk("count",    80'(count),       80'(q.size()));
        chk("empty",    80'(empty),       80'(q.size() == 0));
        chk("full",     80'(full),        80'(q.size() == DEPTH));
        chk("valid",    80'(instr_valid), 80'(q.size() != 0));
        chk("overflow", 80'(overflow),    80'(ovf_m));
        if (q.size() != 0) chk("head", 80'(instr_out), q[0]);
        else               chk("head_not_x", 80'($isunknown(instr_out)), 80'(0));
    endtask

    task automatic drive(input bit le, input logic [31:0] lw, input bit me,
                         input logic [31:0] mw, input bit ue, input logic [15:0] uw,
                         input bit rd, input bit r);
        lower_write_en  = le;  lower_word  = lw;
        middle_write_en = me;  middle_word = mw;
        upper_write_en  = ue;  upper_word  = uw;
        instr_ready     = rd;  rst         = r;
        step();
    endtask

    task automatic commit_rand(input bit rd);
        drive(1, $urandom, 1, $urandom, 1, 16'($urandom), rd, 0);
    endtask

    initial begin
        lo_m = '0; mid_m = '0; ovf_m = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Three-step assembly, fields checked against fixed values.
        drive(1, 32'h0000_0A01, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h00C0_0000, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 16'h1234, 0, 0);
        chk("f_buffer_addr", 80'(instr_out.buffer_addr), 80'h12_3400);
        chk("f_acc_addr",    80'(instr_out.acc_addr),    80'hC000);
        chk("f_length",      80'(instr_out.length),      80'h0000_000A);
        chk("f_opcode",      80'(instr_out.opcode),      80'h01);
        drive(0, 0, 0, 0, 0, 0, 1, 0);

        // All enables in one cycle.
        drive(1, 32'h1111_1111, 1, 32'h2222_2222, 1, 16'h3333, 0, 0);
        chk("forward", 80'(instr_out), 80'h3333_22222222_11111111);
        drive(0, 0, 0, 0, 0, 0, 1, 0);

        // Fill, overflow, drain in order.
        repeat (DEPTH) commit_rand(0);
        chk("filled_count", 80'(count), 80'd32);
        chk("filled_full",  80'(full),  80'd1);
        commit_rand(0);
        chk("ovf_set", 80'(overflow), 80'd1);
        repeat (DEPTH + 2) drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("drained", 80'(empty), 80'd1);
        chk("ovf_held", 80'(overflow), 80'd1);

        // Full with simultaneous commit and pop.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (DEPTH) commit_rand(0);
        commit_rand(1);
        chk("fullpp_count", 80'(count), 80'd32);
        chk("fullpp_ovf",   80'(overflow), 80'd0);
        repeat (DEPTH + 1) drive(0, 0, 0, 0, 0, 0, 1, 0);

        // Random traffic with wrap-around.
        for (int i = 0; i < 250; i++)
            drive(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 2) != 0, 16'($urandom), bit'($urandom_range(0, 1)), 0);
        repeat (DEPTH + 1) drive(0, 0, 0, 0, 0, 0, 1, 0);

        // Reset with entries held and a partially staged instruction.
        repeat (5) commit_rand(0);
        drive(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        drive(1, 32'hCAFE_F00D, 1, 32'h5555_AAAA, 1, 16'h7777, 1, 1);
        chk("rst_count", 80'(count), 80'd0);
        chk("rst_empty", 80'(empty), 80'd1);
        chk("rst_valid", 80'(instr_valid), 80'd0);
        chk("rst_ovf",   80'(overflow), 80'd0);
        drive(0, 0, 0, 0, 1, 16'hABCD, 0, 0);
        chk("zero_staged", 80'(instr_out), 80'hABCD_00000000_00000000);
        drive(0, 0, 0, 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
